// File: rtl/game_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the game-board peers.
// master: the sequencer (drives go / status, receives done / game inputs).
// slave : the peers and the board top (drive done / game inputs, receive go / status).
interface game_frame_sequencer_if #(
    parameter int COORD_W = 32
);
    logic               start;
    logic               left;
    logic               right;
    logic [COORD_W-1:0] doodle_y;
    logic [COORD_W-1:0] min_y;
    logic               new_view;
    logic               doodle_done;
    logic               collide_done;
    logic               view_done;
    logic               block_done;
    logic               render_done;

    logic               left_q;
    logic               right_q;
    logic               doodle_go;
    logic               collide_go;
    logic               view_go;
    logic               block_go;
    logic               render_go;
    logic               busy;
    logic               game_over;
    logic [15:0]        frame_cnt;
    logic               overrun;
    logic               timeout_err;

    modport master (
        input  start, left, right, doodle_y, min_y, new_view,
               doodle_done, collide_done, view_done, block_done, render_done,
        output left_q, right_q, doodle_go, collide_go, view_go, block_go, render_go,
               busy, game_over, frame_cnt, overrun, timeout_err
    );

    modport slave (
        output start, left, right, doodle_y, min_y, new_view,
               doodle_done, collide_done, view_done, block_done, render_done,
        input  left_q, right_q, doodle_go, collide_go, view_go, block_go, render_go,
               busy, game_over, frame_cnt, overrun, timeout_err
    );
endinterface

// File: rtl/game_frame_sequencer.sv
// Per-frame scheduler for the arcade game board.
// Divides i_clk into a physics tick and, on each tick, walks the update phases
// (input latch, doodle, collision, view, optional blocks, render) with go/done
// handshakes. Owns game-over, the per-phase watchdog and tick-overrun detection.
// Optional feature: define GAME_SEQ_PAUSE_EN to add i_pause, which holds the
// sequencer in WAIT_TICK (tick counter frozen, pending tick not consumed).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_TICK | game running, waiting for the next physics tick
// SAMPLE    | one cycle: latch the player buttons for this frame
// DOODLE    | doodle_go high until doodle_done
// COLLIDE   | collide_go high until collide_done
// VIEW      | view_go high until view_done; new_view picks BLOCKS or RENDER
// BLOCKS    | block_go high until block_done
// RENDER    | render_go high until render_done; frame ends here
// OVER      | game over (player fell or a phase timed out), waiting for start
module game_frame_sequencer #(
    parameter int TICK_DIV      = 100,
    parameter int PHASE_TIMEOUT = 255,
    parameter int COORD_W       = 32
) (
    input  logic i_clk,
    input  logic i_reset,
`ifdef GAME_SEQ_PAUSE_EN
    input  logic i_pause,
`endif
    game_frame_sequencer_if.master bus
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int WD_W   = ($clog2(PHASE_TIMEOUT + 1) > 8) ? $clog2(PHASE_TIMEOUT + 1) : 8;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(PHASE_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_TICK, S_SAMPLE, S_DOODLE, S_COLLIDE,
        S_VIEW, S_BLOCKS, S_RENDER, S_OVER
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                r_tick_pend;
    logic [WD_W-1:0]     r_wd;
    logic                r_left_q;
    logic                r_right_q;
    logic [15:0]         r_frame_cnt;
    logic                r_overrun;
    logic                r_timeout;

    logic                w_paused;
    logic                w_run;
    logic                w_tick;
    logic                w_phase;
    logic                w_done;
    logic                w_restart;
    logic                w_consume;
    logic                w_frame_end;
    logic                w_timeout;
    logic                w_fell;
    logic [COORD_W-1:0]  w_doodle_y;
    logic [COORD_W-1:0]  w_min_y;

`ifdef GAME_SEQ_PAUSE_EN
    assign w_paused = i_pause && (r_state == S_WAIT_TICK);
`else
    assign w_paused = 1'b0;
`endif

    assign w_doodle_y = bus.doodle_y;
    assign w_min_y    = bus.min_y;
    assign w_fell     = (w_doodle_y < w_min_y);

    // Tick counter only advances while a game is running and not paused.
    assign w_run  = (r_state != S_IDLE) && (r_state != S_OVER) && !w_paused;
    assign w_tick = w_run && (r_tick_cnt == TICK_LAST);

    // Next-state logic and per-cycle strobes for the datapath registers.
    always_comb begin
        w_next      = r_state;
        w_phase     = 1'b0;
        w_done      = 1'b0;
        w_restart   = 1'b0;
        w_consume   = 1'b0;
        w_frame_end = 1'b0;
        w_timeout   = 1'b0;

        case (r_state)
            S_DOODLE:  begin w_phase = 1'b1; w_done = bus.doodle_done;  end
            S_COLLIDE: begin w_phase = 1'b1; w_done = bus.collide_done; end
            S_VIEW:    begin w_phase = 1'b1; w_done = bus.view_done;    end
            S_BLOCKS:  begin w_phase = 1'b1; w_done = bus.block_done;   end
            S_RENDER:  begin w_phase = 1'b1; w_done = bus.render_done;  end
            default:   begin w_phase = 1'b0; w_done = 1'b0;             end
        endcase

        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    w_next    = S_WAIT_TICK;
                    w_restart = 1'b1;
                end
            end
            S_WAIT_TICK: begin
                if (r_tick_pend && !w_paused) begin
                    w_next    = S_SAMPLE;
                    w_consume = 1'b1;
                end
            end
            S_SAMPLE: w_next = S_DOODLE;
            default: begin
                // Done wins over the watchdog when both land on the same cycle.
                if (w_done) begin
                    case (r_state)
                        S_DOODLE:  w_next = S_COLLIDE;
                        S_COLLIDE: w_next = S_VIEW;
                        S_VIEW:    w_next = bus.new_view ? S_BLOCKS : S_RENDER;
                        S_BLOCKS:  w_next = S_RENDER;
                        S_RENDER: begin
                            w_frame_end = 1'b1;
                            w_next      = w_fell ? S_OVER : S_WAIT_TICK;
                        end
                        default:   w_next = S_IDLE;
                    endcase
                end else if (w_phase && (r_wd == WD_LAST)) begin
                    w_next    = S_OVER;
                    w_timeout = 1'b1;
                end
            end
        endcase
    end

    // State register; async reset also drops every go immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Physics tick divider with a single-deep pending flag and sticky overrun.
    // A tick landing on the consume cycle re-arms pend rather than overrunning.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt  <= '0;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_restart) begin
            r_tick_cnt  <= '0;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_run) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_tick_pend <= 1'b1;
                if (r_tick_pend && !w_consume) r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_tick_pend <= 1'b0;
            end
        end
    end

    // Per-phase watchdog: restarts on every state change, counts while in a phase.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                 r_wd <= '0;
        else if (w_next != r_state)  r_wd <= '0;
        else if (w_phase)            r_wd <= r_wd + 1'b1;
    end

    // Button latch (both pressed cancels out), frame counter and timeout flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_left_q    <= 1'b0;
            r_right_q   <= 1'b0;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == S_SAMPLE) begin
                r_left_q  <= bus.left & ~bus.right;
                r_right_q <= bus.right & ~bus.left;
            end
            if (w_restart)        r_frame_cnt <= '0;
            else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_restart)        r_timeout <= 1'b0;
            else if (w_timeout)   r_timeout <= 1'b1;
        end
    end

    assign bus.doodle_go   = (r_state == S_DOODLE);
    assign bus.collide_go  = (r_state == S_COLLIDE);
    assign bus.view_go     = (r_state == S_VIEW);
    assign bus.block_go    = (r_state == S_BLOCKS);
    assign bus.render_go   = (r_state == S_RENDER);
    assign bus.busy        = (r_state != S_IDLE) && (r_state != S_WAIT_TICK) && (r_state != S_OVER);
    assign bus.game_over   = (r_state == S_OVER);
    assign bus.left_q      = r_left_q;
    assign bus.right_q     = r_right_q;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Self-checking bench for game_frame_sequencer (TICK_DIV=8, PHASE_TIMEOUT=10).
// A table of per-frame vectors drives button / coordinate / new_view patterns
// with all done lines tied high; hand-written sequences cover the watchdog,
// tick overrun, start-ignored-mid-frame and async reset mid-phase.
module tb_game_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef GAME_SEQ_PAUSE_EN
    logic pause = 1'b0;
`endif

    game_frame_sequencer_if #(.COORD_W(32)) bus ();

    game_frame_sequencer #(
        .TICK_DIV      (8),
        .PHASE_TIMEOUT (10),
        .COORD_W       (32)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
`ifdef GAME_SEQ_PAUSE_EN
        .i_pause (pause),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // go vector ordering: {render, block, view, collide, doodle}
    localparam logic [31:0] SEQ_NOBLK = {12'd0, 5'b00001, 5'b00010, 5'b00100, 5'b10000};
    localparam logic [31:0] SEQ_BLK   = {7'd0, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    typedef struct {
        logic        l;
        logic        r;
        logic        drop;
        int          nv_mode;   // 0: never, 1: only on the view_done cycle, 2: everywhere except it
        logic [31:0] dy;
        logic [31:0] my;
        logic        exp_lq;
        logic        exp_rq;
        logic        exp_over;
        logic [31:0] exp_seq;
        logic [15:0] exp_fc;
    } frame_vec_t;

    frame_vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] gos();
        return {bus.render_go, bus.block_go, bus.view_go, bus.collide_go, bus.doodle_go};
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        int          n;
        logic [31:0] seq;
        logic        lq_ok;
        bus.left     = v.l;
        bus.right    = v.r;
        bus.doodle_y = v.dy;
        bus.min_y    = v.my;
        bus.new_view = (v.nv_mode == 2);
        n = 0;
        while (!bus.busy && n < 20) begin step(); n++; end
        chk($sformatf("f%0d_start", idx), bus.busy, 1);
        if (!bus.busy) return;
        if (idx > 0) chk($sformatf("f%0d_period", idx), cyc - last_start, 8);
        last_start = cyc;
        seq   = '0;
        lq_ok = 1'b1;
        n     = 0;
        while (bus.busy && n < 30) begin
            if (gos() != 5'd0) begin
                seq = (seq << 5) | {27'd0, gos()};
                if (bus.left_q !== v.exp_lq || bus.right_q !== v.exp_rq) lq_ok = 1'b0;
            end
            if (bus.doodle_go && v.drop) bus.left = 1'b0;
            bus.new_view = bus.view_go ? (v.nv_mode == 1) : (v.nv_mode == 2);
            step();
            n++;
        end
        chk($sformatf("f%0d_end", idx), bus.busy, 0);
        chk($sformatf("f%0d_go_seq", idx), seq, v.exp_seq);
        chk($sformatf("f%0d_lr_q_steady", idx), lq_ok, 1);
        chk($sformatf("f%0d_left_q", idx), bus.left_q, v.exp_lq);
        chk($sformatf("f%0d_right_q", idx), bus.right_q, v.exp_rq);
        chk($sformatf("f%0d_frame_cnt", idx), bus.frame_cnt, v.exp_fc);
        chk($sformatf("f%0d_game_over", idx), bus.game_over, v.exp_over);
        bus.new_view = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not end, required end before 200000");
        $fatal(1);
    end

    initial begin
        int n;

        tbl[0] = '{l:1'b0, r:1'b0, drop:1'b0, nv_mode:0, dy:32'd500,        my:32'd100,
                   exp_lq:1'b0, exp_rq:1'b0, exp_over:1'b0, exp_seq:SEQ_NOBLK, exp_fc:16'd1};
        tbl[1] = '{l:1'b1, r:1'b0, drop:1'b1, nv_mode:1, dy:32'd100,        my:32'd100,
                   exp_lq:1'b1, exp_rq:1'b0, exp_over:1'b0, exp_seq:SEQ_BLK,   exp_fc:16'd2};
        tbl[2] = '{l:1'b1, r:1'b1, drop:1'b0, nv_mode:2, dy:32'h8000_0000, my:32'd1,
                   exp_lq:1'b0, exp_rq:1'b0, exp_over:1'b0, exp_seq:SEQ_NOBLK, exp_fc:16'd3};
        tbl[3] = '{l:1'b0, r:1'b1, drop:1'b0, nv_mode:0, dy:32'd0,          my:32'd0,
                   exp_lq:1'b0, exp_rq:1'b1, exp_over:1'b0, exp_seq:SEQ_NOBLK, exp_fc:16'd4};
        tbl[4] = '{l:1'b1, r:1'b0, drop:1'b0, nv_mode:0, dy:32'd99,         my:32'd100,
                   exp_lq:1'b1, exp_rq:1'b0, exp_over:1'b1, exp_seq:SEQ_NOBLK, exp_fc:16'd5};

        bus.start        = 1'b0;
        bus.left         = 1'b0;
        bus.right        = 1'b0;
        bus.doodle_y     = '0;
        bus.min_y        = '0;
        bus.new_view     = 1'b0;
        bus.doodle_done  = 1'b1;
        bus.collide_done = 1'b1;
        bus.view_done    = 1'b1;
        bus.block_done   = 1'b1;
        bus.render_done  = 1'b1;

        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_go",          gos(),           0);
        chk("rst_busy",        bus.busy,        0);
        chk("rst_game_over",   bus.game_over,   0);
        chk("rst_frame_cnt",   bus.frame_cnt,   0);
        chk("rst_overrun",     bus.overrun,     0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_lr_q",        {bus.left_q, bus.right_q}, 0);
        rst = 1'b0;
        repeat (12) step();
        chk("idle_no_frame", bus.busy | (gos() != 0), 0);

        // Table-driven frames, all done tied high
        pulse_start();
        chk("start_wait_busy", bus.busy, 0);
        for (int i = 0; i < 5; i++) run_frame(tbl[i], i);
        chk("table_overrun", bus.overrun, 0);
        repeat (10) step();
        chk("over_hold",      bus.game_over, 1);
        chk("over_go",        gos(),         0);
        chk("over_frame_cnt", bus.frame_cnt, 5);

        // Watchdog: collide_done held low
        bus.doodle_y     = 32'd500;
        bus.min_y        = 32'd100;
        bus.collide_done = 1'b0;
        pulse_start();
        chk("restart_frame_cnt", bus.frame_cnt, 0);
        chk("restart_game_over", bus.game_over, 0);
        n = 0;
        while (!bus.collide_go && n < 30) begin step(); n++; end
        chk("wd_collide_seen", bus.collide_go, 1);
        n = 0;
        while (bus.collide_go && n < 30) begin step(); n++; end
        chk("wd_go_cycles",   n,               10);
        chk("wd_timeout_err", bus.timeout_err, 1);
        chk("wd_game_over",   bus.game_over,   1);
        chk("wd_go_low",      gos(),           0);
        bus.collide_done = 1'b1;

        // Overrun: long doodle and render phases span two ticks
        bus.doodle_done = 1'b0;
        bus.render_done = 1'b0;
        pulse_start();
        chk("wd_restart_clear", bus.timeout_err, 0);
        chk("wd_restart_over",  bus.game_over,   0);
        n = 0;
        while (!bus.doodle_go && n < 30) begin step(); n++; end
        chk("ovr_doodle_seen", bus.doodle_go, 1);
        repeat (7) step();
        chk("ovr_doodle_held", bus.doodle_go, 1);
        bus.doodle_done = 1'b1;
        n = 0;
        while (!bus.render_go && n < 10) begin step(); n++; end
        chk("ovr_render_seen",   bus.render_go, 1);
        chk("ovr_not_yet",       bus.overrun,   0);
        repeat (7) step();
        bus.render_done = 1'b1;
        step();
        chk("ovr_frame_done",    bus.busy,      0);
        chk("ovr_overrun",       bus.overrun,   1);
        chk("ovr_frame_cnt",     bus.frame_cnt, 1);

        // Pending frame runs; start mid-frame must be ignored
        n = 0;
        while (!bus.doodle_go && n < 10) begin step(); n++; end
        chk("pend_frame_runs", bus.doodle_go, 1);
        pulse_start();
        n = 0;
        while (bus.busy && n < 20) begin step(); n++; end
        chk("pend_frame_end",   bus.busy,      0);
        chk("pend_frame_cnt",   bus.frame_cnt, 2);
        chk("overrun_sticky",   bus.overrun,   1);
        chk("pend_game_over",   bus.game_over, 0);

        // Async reset in the middle of DOODLE
        bus.doodle_done = 1'b0;
        n = 0;
        while (!bus.doodle_go && n < 30) begin step(); n++; end
        chk("rstmid_doodle_seen", bus.doodle_go, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_go_drop",   gos(),         0);
        chk("rstmid_busy",      bus.busy,      0);
        chk("rstmid_frame_cnt", bus.frame_cnt, 0);
        chk("rstmid_overrun",   bus.overrun,   0);
        step();
        rst = 1'b0;
        bus.doodle_done = 1'b1;
        repeat (20) step();
        chk("rstmid_idle", bus.busy | (gos() != 0) | bus.game_over, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
